// File: rtl/branch_resolver_pkg.sv
// Shared types and helpers for the gshare branch resolution path.
// Optional feature macro: BRANCH_RESOLVER_STATS_EN (branch/mispredict counters).
package branch_pkg;

    localparam int          PHT_IDX_W  = 8;
    localparam logic [31:0] INSN_BYTES = 32'd4;
    localparam logic [31:0] CNT_MAX    = 32'hFFFF_FFFF;

    // Prediction metadata captured at decode for one in-flight branch.
    typedef struct packed {
        logic                 prediction;
        logic [PHT_IDX_W-1:0] pht_index;
        logic [31:0]          pc;
        logic [31:0]          target;
    } bp_rec_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } br_state_e;

    // Wrong direction, or right "taken" direction but to the wrong place.
    function automatic logic is_mispredict(input bp_rec_t    rec,
                                           input logic        taken,
                                           input logic [31:0] target);
        logic dir_wrong;
        logic tgt_wrong;
        dir_wrong = (rec.prediction != taken);
        tgt_wrong = taken & rec.prediction & (rec.target != target);
        return dir_wrong | tgt_wrong;
    endfunction

    // Where fetch must resume: the real target, or the fall-through (wraps at 32 bits).
    function automatic logic [31:0] correct_pc(input bp_rec_t    rec,
                                               input logic        taken,
                                               input logic [31:0] target);
        return taken ? target : (rec.pc + INSN_BYTES);
    endfunction

    // Saturating event counter step.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == CNT_MAX) ? value : (value + 32'd1);
    endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Decode/MEM side request signals and predictor/fetch side result signals
// of the branch resolver, bundled as one interface.
interface branch_resolver_if;
    import branch_pkg::*;

    logic                 dec_valid;
    logic                 dec_stall;
    logic                 dec_prediction;
    logic [PHT_IDX_W-1:0] dec_pht_index;
    logic [31:0]          dec_pc;
    logic [31:0]          dec_target;
    logic                 mem_valid;
    logic                 mem_taken;
    logic [31:0]          mem_target;

    logic                 update_valid;
    logic                 update_taken;
    logic [PHT_IDX_W-1:0] update_index;
    logic                 flush;
    logic                 redirect_valid;
    logic [31:0]          redirect_pc;
    logic                 overflow_err;
    logic                 underflow_err;

    // Pipeline side: drives decode/resolve, observes updates and redirects.
    modport master (
        output dec_valid, dec_stall, dec_prediction, dec_pht_index, dec_pc, dec_target,
        output mem_valid, mem_taken, mem_target,
        input  update_valid, update_taken, update_index, flush,
        input  redirect_valid, redirect_pc, overflow_err, underflow_err
    );

    // Resolver side.
    modport slave (
        input  dec_valid, dec_stall, dec_prediction, dec_pht_index, dec_pc, dec_target,
        input  mem_valid, mem_taken, mem_target,
        output update_valid, update_taken, update_index, flush,
        output redirect_valid, redirect_pc, overflow_err, underflow_err
    );

endinterface

// File: rtl/branch_resolver_rec_fifo.sv
// In-order queue of branch prediction records. Pointers carry one extra
// wrap bit so full and empty are distinguishable. A push and pop in the
// same cycle on a full queue is legal: the write lands in the slot being
// vacated. Clear wins over push and pop.
module branch_rec_fifo
    import branch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  bp_rec_t push_rec,
    input  logic    pop,
    input  logic    clear,
    output logic    full,
    output logic    empty,
    output bp_rec_t head
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    bp_rec_t       mem_q [DEPTH];
    bp_rec_t       mem_d [DEPTH];

    // Status flags and the oldest record, straight from the pointers.
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        head  = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Next pointer and storage contents.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (clear) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q[AW-1:0]] = push_rec;
                wr_ptr_d                = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Pointer registers; reset empties the queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Record storage; contents are meaningless while empty, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: compares queued gshare predictions with MEM outcomes,
// trains the PHT and redirects/flushes the pipe on a mispredict.
// Optional feature macro: BRANCH_RESOLVER_STATS_EN adds saturating
// stat_branches / stat_mispredicts counters.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    branch_resolver_if.slave bus
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);

    bp_rec_t   push_rec_s;
    bp_rec_t   head_s;
    logic      full_s;
    logic      empty_s;
    logic      is_idle_s;
    logic      push_req_s;
    logic      push_s;
    logic      pop_s;
    logic      mispredict_s;
    logic      overflow_set_s;
    logic      underflow_set_s;

    br_state_e state_q;
    br_state_e state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    logic                 update_valid_q;
    logic                 update_valid_d;
    logic                 update_taken_q;
    logic                 update_taken_d;
    logic [PHT_IDX_W-1:0] update_index_q;
    logic [PHT_IDX_W-1:0] update_index_d;
    logic                 flush_q;
    logic                 flush_d;
    logic                 redirect_valid_q;
    logic                 redirect_valid_d;
    logic [31:0]          redirect_pc_q;
    logic [31:0]          redirect_pc_d;
    logic                 overflow_err_q;
    logic                 overflow_err_d;
    logic                 underflow_err_q;
    logic                 underflow_err_d;

    branch_rec_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_s),
        .push_rec (push_rec_s),
        .pop      (pop_s),
        .clear    (mispredict_s),
        .full     (full_s),
        .empty    (empty_s),
        .head     (head_s)
    );

    // Queue control: accept/resolve only while IDLE; a pop frees a full slot;
    // a push alongside a mispredict is wrong-path and is discarded.
    always_comb begin
        push_rec_s.prediction = bus.dec_prediction;
        push_rec_s.pht_index  = bus.dec_pht_index;
        push_rec_s.pc         = bus.dec_pc;
        push_rec_s.target     = bus.dec_target;
        is_idle_s       = (state_q == IDLE);
        push_req_s      = bus.dec_valid & ~bus.dec_stall & is_idle_s;
        pop_s           = bus.mem_valid & ~empty_s & is_idle_s;
        mispredict_s    = pop_s & is_mispredict(head_s, bus.mem_taken, bus.mem_target);
        push_s          = push_req_s & (~full_s | pop_s) & ~mispredict_s;
        overflow_set_s  = push_req_s & full_s & ~pop_s;
        underflow_set_s = bus.mem_valid & empty_s & is_idle_s;
    end

    // Flush sequencer: a mispredict holds the pipe in FLUSH for FLUSH_CYCLES cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mispredict_s) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end
            end
            FLUSH: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = FLUSH;
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Next values of the registered outputs; data fields read zero when idle.
    always_comb begin
        update_valid_d   = pop_s;
        update_taken_d   = pop_s & bus.mem_taken;
        update_index_d   = pop_s ? head_s.pht_index : {PHT_IDX_W{1'b0}};
        redirect_valid_d = mispredict_s;
        redirect_pc_d    = mispredict_s ? correct_pc(head_s, bus.mem_taken, bus.mem_target)
                                        : 32'h0000_0000;
        flush_d          = (state_d == FLUSH);
        overflow_err_d   = overflow_err_q | overflow_set_s;
        underflow_err_d  = underflow_err_q | underflow_set_s;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            cnt_q            <= CNT_ZERO;
            update_valid_q   <= 1'b0;
            update_taken_q   <= 1'b0;
            update_index_q   <= {PHT_IDX_W{1'b0}};
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'h0000_0000;
            overflow_err_q   <= 1'b0;
            underflow_err_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            update_valid_q   <= update_valid_d;
            update_taken_q   <= update_taken_d;
            update_index_q   <= update_index_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            overflow_err_q   <= overflow_err_d;
            underflow_err_q  <= underflow_err_d;
        end
    end

    assign bus.update_valid   = update_valid_q;
    assign bus.update_taken   = update_taken_q;
    assign bus.update_index   = update_index_q;
    assign bus.flush          = flush_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.overflow_err   = overflow_err_q;
    assign bus.underflow_err  = underflow_err_q;

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_branches_d;
    logic [31:0] stat_mispredicts_q;
    logic [31:0] stat_mispredicts_d;

    // Count every resolved branch and every mispredict, saturating.
    always_comb begin
        stat_branches_d    = pop_s ? sat_inc(stat_branches_q) : stat_branches_q;
        stat_mispredicts_d = mispredict_s ? sat_inc(stat_mispredicts_q) : stat_mispredicts_q;
    end

    // Statistic counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_branches_q    <= 32'h0000_0000;
            stat_mispredicts_q <= 32'h0000_0000;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: a queue-based reference model
// predicts each cycle's outcome, a monitor compares on the falling edge.
module tb_branch_resolver;
    localparam int DEPTH        = 4;
    localparam int FLUSH_CYCLES = 2;

    typedef struct {
        logic        pred;
        logic [7:0]  idx;
        logic [31:0] pc;
        logic [31:0] tgt;
    } rec_t;

    typedef struct {
        logic        taken;
        logic [7:0]  idx;
        logic        redir;
        logic [31:0] rpc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_drv = 1'b0;
    logic mon_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    rec_t mq[$];
    exp_t sb[$];
    int   flush_rem = 0;
    logic exp_flush = 1'b0;
    logic exp_ovf = 1'b0;
    logic exp_udf = 1'b0;
    logic [31:0] exp_br = 32'd0;
    logic [31:0] exp_mp = 32'd0;

    branch_resolver_if bus();

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    branch_resolver #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef BRANCH_RESOLVER_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one call per cycle, predicting what appears after the edge.
    task automatic model_step();
        rec_t h;
        exp_t e;
        logic mis;
        mis = 1'b0;
        if (!rst_drv) begin
            mq.delete();
            flush_rem = 0;
            exp_ovf = 1'b0;
            exp_udf = 1'b0;
            exp_br = 32'd0;
            exp_mp = 32'd0;
        end else if (flush_rem > 0) begin
            flush_rem--;
        end else begin
            if (bus.mem_valid) begin
                if (mq.size() == 0) begin
                    exp_udf = 1'b1;
                end else begin
                    h = mq.pop_front();
                    if (exp_br != 32'hFFFF_FFFF) exp_br = exp_br + 32'd1;
                    mis = (h.pred != bus.mem_taken) ||
                          (bus.mem_taken && h.tgt != bus.mem_target);
                    e.taken = bus.mem_taken;
                    e.idx   = h.idx;
                    e.redir = mis;
                    e.rpc   = bus.mem_taken ? bus.mem_target : h.pc + 32'd4;
                    sb.push_back(e);
                    if (mis) begin
                        mq.delete();
                        flush_rem = FLUSH_CYCLES;
                        if (exp_mp != 32'hFFFF_FFFF) exp_mp = exp_mp + 32'd1;
                    end
                end
            end
            if (bus.dec_valid && !bus.dec_stall && !mis) begin
                if (mq.size() < DEPTH) begin
                    h.pred = bus.dec_prediction;
                    h.idx  = bus.dec_pht_index;
                    h.pc   = bus.dec_pc;
                    h.tgt  = bus.dec_target;
                    mq.push_back(h);
                end else begin
                    exp_ovf = 1'b1;
                end
            end
        end
        exp_flush = (flush_rem > 0);
    endtask

    task automatic cyc(input logic dv, input logic st, input logic pr, input logic [7:0] ix,
                       input logic [31:0] pc, input logic [31:0] tg,
                       input logic mv, input logic mt, input logic [31:0] mtg);
        @(negedge clk);
        #1;
        rst_n              = rst_drv;
        bus.dec_valid      = dv;
        bus.dec_stall      = st;
        bus.dec_prediction = pr;
        bus.dec_pht_index  = ix;
        bus.dec_pc         = pc;
        bus.dec_target     = tg;
        bus.mem_valid      = mv;
        bus.mem_taken      = mt;
        bus.mem_target     = mtg;
        model_step();
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic push(input logic pr, input logic [7:0] ix, input logic [31:0] pc,
                        input logic [31:0] tg);
        cyc(1'b1, 1'b0, pr, ix, pc, tg, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic res(input logic mt, input logic [31:0] mtg);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b1, mt, mtg);
    endtask

    task automatic do_reset();
        rst_drv = 1'b0;
        idle();
        rst_drv = 1'b1;
    endtask

    // Monitor: compares DUT outputs with the scoreboard each falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("flush", bus.flush, exp_flush);
            chk("overflow_err", bus.overflow_err, exp_ovf);
            chk("underflow_err", bus.underflow_err, exp_udf);
`ifdef BRANCH_RESOLVER_STATS_EN
            chk("stat_branches", stat_branches, exp_br);
            chk("stat_mispredicts", stat_mispredicts, exp_mp);
`endif
            if (bus.update_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_update", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("update_taken", bus.update_taken, e.taken);
                    chk("update_index", bus.update_index, e.idx);
                    chk("redirect_valid", bus.redirect_valid, e.redir);
                    if (e.redir) chk("redirect_pc", bus.redirect_pc, e.rpc);
                end
            end else begin
                chk("redirect_without_update", bus.redirect_valid, 32'd0);
            end
            if (sb.size() != 0) begin
                chk("missing_update", bus.update_valid, 32'd1);
                sb.delete();
            end
        end
    end

    initial begin
        logic [31:0] tpool [2];
        logic        mt;
        logic [31:0] mtg;
        tpool[0] = 32'h0000_1000;
        tpool[1] = 32'h0000_2000;

        do_reset();
        mon_en = 1'b1;
        idle();
        chk("reset_update_valid", bus.update_valid, 32'd0);
        chk("reset_redirect_valid", bus.redirect_valid, 32'd0);
        chk("reset_redirect_pc", bus.redirect_pc, 32'd0);
        chk("reset_flush", bus.flush, 32'd0);
        chk("reset_errors", {bus.overflow_err, bus.underflow_err}, 32'd0);

        // Correct not-taken.
        push(1'b0, 8'h3C, 32'h100, 32'h140);
        res(1'b0, 32'h0);
        idle();
        chk("nt_update_valid", bus.update_valid, 32'd1);
        chk("nt_update_taken", bus.update_taken, 32'd0);
        chk("nt_update_index", bus.update_index, 32'h3C);
        chk("nt_no_flush", bus.flush, 32'd0);
        chk("nt_no_redirect", bus.redirect_valid, 32'd0);

        // Taken mispredict: flush for exactly two cycles.
        push(1'b0, 8'h55, 32'h200, 32'h240);
        res(1'b1, 32'h240);
        idle();
        chk("tk_redirect_valid", bus.redirect_valid, 32'd1);
        chk("tk_redirect_pc", bus.redirect_pc, 32'h240);
        chk("tk_flush_c1", bus.flush, 32'd1);
        idle();
        chk("tk_flush_c2", bus.flush, 32'd1);
        chk("tk_redirect_pulse", bus.redirect_valid, 32'd0);
        idle();
        chk("tk_flush_c3", bus.flush, 32'd0);

        // Predicted taken, actually not taken: fall-through.
        push(1'b1, 8'h11, 32'h7C, 32'h80);
        res(1'b0, 32'h0);
        idle();
        chk("pt_nt_redirect_pc", bus.redirect_pc, 32'h80);
        idle();
        idle();
        // Taken but to a different target.
        push(1'b1, 8'h12, 32'h300, 32'h80);
        res(1'b1, 32'h90);
        idle();
        chk("tgt_redirect_pc", bus.redirect_pc, 32'h90);
        idle();
        idle();

        // Overflow on the fifth push.
        for (int i = 0; i < 5; i++) push(1'b0, 8'(i), 32'h400 + 32'(i * 4), 32'h0);
        idle();
        chk("ovf_fifth_push", bus.overflow_err, 32'd1);
        do_reset();
        for (int i = 0; i < 4; i++) push(1'b0, 8'(i), 32'h500 + 32'(i * 4), 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 8'h44, 32'h510, 32'h0, 1'b1, 1'b0, 32'h0);
        idle();
        chk("full_pushpop_no_err", bus.overflow_err, 32'd0);
        chk("full_pushpop_update", bus.update_index, 32'h00);
        push(1'b0, 8'h45, 32'h514, 32'h0);
        idle();
        chk("full_still_four", bus.overflow_err, 32'd1);
        for (int i = 0; i < 4; i++) res(1'b0, 32'h0);
        idle();

        // Mispredict with younger records and a same-cycle push: all cleared.
        do_reset();
        for (int i = 0; i < 4; i++) push(1'b0, 8'h60 + 8'(i), 32'h600 + 32'(i * 4), 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 8'h70, 32'h700, 32'h0, 1'b1, 1'b1, 32'h400);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("clr_redirect_pc", bus.redirect_pc, 32'h400);
        res(1'b0, 32'h0);
        idle();
        chk("clr_flush_no_update", bus.update_valid, 32'd0);
        chk("clr_flush_no_udf", bus.underflow_err, 32'd0);
        res(1'b0, 32'h0);
        idle();
        chk("clr_then_udf", bus.underflow_err, 32'd1);

        // Reset in the middle of FLUSH.
        push(1'b0, 8'h21, 32'h800, 32'h0);
        res(1'b1, 32'h500);
        idle();
        chk("mid_flush_high", bus.flush, 32'd1);
        do_reset();
        idle();
        chk("mid_rst_flush", bus.flush, 32'd0);
        chk("mid_rst_errors", {bus.overflow_err, bus.underflow_err}, 32'd0);
        res(1'b0, 32'h0);
        idle();
        chk("mid_rst_empty", bus.underflow_err, 32'd1);

        // Three resolutions, one mispredict.
        do_reset();
        push(1'b0, 8'h01, 32'h900, 32'h0);
        res(1'b0, 32'h0);
        push(1'b1, 8'h02, 32'h904, 32'hA00);
        res(1'b1, 32'hA00);
        push(1'b1, 8'h03, 32'h908, 32'hB00);
        res(1'b1, 32'hB04);
        idle();
        idle();
        idle();
`ifdef BRANCH_RESOLVER_STATS_EN
        chk("stats_branches_3", stat_branches, 32'd3);
        chk("stats_mispredicts_1", stat_mispredicts, 32'd1);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if (mq.size() > 0 && $urandom_range(3, 0) != 0) begin
                mt  = mq[0].pred;
                mtg = mq[0].tgt;
            end else begin
                mt  = 1'($urandom_range(1, 0));
                mtg = tpool[$urandom_range(1, 0)];
            end
            cyc(1'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0),
                1'($urandom_range(1, 0)), 8'($urandom), {$urandom, 2'b00} >> 2 << 2,
                tpool[$urandom_range(1, 0)], ($urandom_range(2, 0) == 0), mt, mtg);
        end
        idle();
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
